range_sequencer: RTL
====================

Name: range_sequencer

Overview:
- Shares one RangeFinder datapath between NREQ requesters, each of which streams a burst of samples.
- Round-robin arbitration grants one burst at a time; the block drives go/finish/data_in into the RangeFinder and captures its range.
- Returns the range to the winning requester through a valid/ready result port.
- Sits between the sample sources and a single RangeFinder instance.

Parameters:
WIDTH, 16, sample and range width (must match the RangeFinder WIDTH)
NREQ, 4, number of requesters (2..16)
IDW, $clog2(NREQ), requester-id width (derived; do not override)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset; RangeFinder reset is tied to ~reset at integration
req_valid  in  NREQ  per-requester sample valid
req_data  in  NREQ*WIDTH  flattened samples; requester i occupies bits [i*WIDTH +: WIDTH]
req_last  in  NREQ  marks the final sample of a burst
req_ready  out  NREQ  per-requester accept; one-hot or zero
rf_data_in  out  WIDTH  to RangeFinder data_in
rf_go  out  1  to RangeFinder go
rf_finish  out  1  to RangeFinder finish
rf_range  in  WIDTH  from RangeFinder range
rf_debug_error  in  1  from RangeFinder debug_error
res_valid  out  1  result available
res_ready  in  1  result consumer accept
res_id  out  IDW  requester that owns the result
res_range  out  WIDTH  max minus min of the burst
res_error  out  1  RangeFinder flagged an error during the finish cycle

Behaviour:
- Beat = cycle where req_valid[owner] && req_ready[owner].
- Reset (reset==0, async):
  - state=IDLE, owner=0, last_grant=NREQ-1, first=1, hold_data=0.
  - All outputs 0: req_ready, rf_go, rf_finish, rf_data_in, res_valid, res_id, res_range, res_error.
- Reset mid-burst abandons the burst: no result is produced, and the requester must restart its burst.
- States:
  - IDLE: req_ready=0. If any req_valid, rr_arbiter picks the first set bit searching from last_grant+1 with wrap-around. Register owner, set last_grant=owner, first=1, go to STREAM next cycle. If no req_valid, stay in IDLE.
  - STREAM: req_ready[owner]=req_valid[owner]; all other bits 0.
    - First beat, req_last=0: rf_go=1, rf_data_in=sample, first<=0.
    - Later beat, req_last=0: rf_go=0, rf_finish=0, rf_data_in=sample.
    - Later beat, req_last=1: rf_finish=1, rf_data_in=sample. At that edge res_range<=rf_range and res_error<=rf_debug_error (both combinational in the finish cycle and including this sample). Go to RESULT.
    - First beat with req_last=1 (single-sample burst): rf_go and rf_finish stay 0, because go+finish together is a RangeFinder error. res_range<=0, res_error<=0. Go to RESULT.
    - No beat (bubble): rf_go=rf_finish=0, rf_data_in=hold_data. The RangeFinder samples every cycle, so re-presenting the last accepted sample leaves min/max unchanged.
    - Every beat loads hold_data.
  - RESULT: res_valid=1; res_id/res_range/res_error held stable; req_ready=0. When res_ready=1, go to IDLE next cycle.
- rf_go and rf_finish are never both 1.
- Latency: the result is visible the cycle after the last beat. The earliest next grant is IDLE one cycle after the result is accepted.
- Throughput: one sample per cycle in STREAM.
- Fairness: a requester whose req_valid stays set is granted within NREQ bursts.
- Owner req_valid dropping mid-burst is legal. Non-owner inputs are ignored.
- Subtraction wrap is handled inside the RangeFinder; the controller only registers the result.

Decomposition:
- Package range_seq_pkg:
  - typedef enum logic [1:0] {IDLE, STREAM, RESULT} seq_state_t
  - localparam DEFAULT_WIDTH=16, DEFAULT_NREQ=4
- Sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs: req, last_grant.
  - Outputs: one-hot grant, grant_id, any.
  - Purely combinational; the pointer register lives in range_sequencer.
- The RangeFinder and MagComparator are instantiated only in the bench/top, not inside this block.

Test Plan:
- Req0 burst 7FFF,8000,8001,7FFE,7FFF(last) -> rf_go only on beat 1, rf_finish on beat 5, res_valid next cycle, res_id=0, res_range=0003, res_error=0.
- Req1 burst 0100,0000,FFFF,0200(last) with a 2-cycle bubble after 0000 -> rf_data_in repeats 0000 during the bubble, res_range=FFFF.
- Req2 single sample 1234 with last=1 -> rf_go=rf_finish=0 throughout, res_range=0000, res_id=2, res_error=0.
- All four req_valid held high, each burst 2 samples -> grants in order 0,1,2,3,0; res_ready stalled 3 cycles on the first result -> res_* held stable and req_ready=0 until accepted.
- Reset driven low during STREAM of req3 -> all outputs 0 immediately (async), state IDLE; after release a new req1 burst 0005,0009 -> res_range=0004, no stale data.
- Assertion throughout: !(rf_go && rf_finish), $onehot0(req_ready), res_error=0 for every legal burst.

Source files
------------

// File: rtl/range_seq_pkg.sv
// Shared types and defaults for the range sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package range_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    RESULT
  } seq_state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_NREQ  = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit searching upward from last_grant+1 with wrap.
// Latency: purely combinational; the pointer register lives in the caller.
// Backpressure: none; the caller decides when a grant is taken.
//
// Ports:
//   req        per-requester request bits
//   last_grant id of the most recently granted requester
//   grant      one-hot grant (zero when no request)
//   grant_id   binary id of the granted requester
//   any        at least one request present
module rr_arbiter
  import range_seq_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);

  logic [IDW-1:0] cand;

  // base is at most NREQ-1, so one conditional subtract covers the wrap.
  function automatic int wrap_next(input int base, input int k);
    int v;
    v = base + 1 + k;
    if (v >= NREQ) v = v - NREQ;
    return v;
  endfunction

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'(wrap_next(int'(last_grant), k));
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_id    = cand;
      end
    end
  end

endmodule

// File: rtl/range_sequencer.sv
// Shares one RangeFinder between NREQ burst requesters and returns each burst's range.
// Latency: result valid the cycle after the last beat; next grant one IDLE cycle after accept.
// Backpressure: req_ready follows owner req_valid in STREAM; RESULT holds until res_ready.
//
// Ports:
//   clock, reset (async active-low)
//   req_valid/req_data/req_last/req_ready  per-requester sample stream (flattened data)
//   rf_data_in/rf_go/rf_finish             drive into the RangeFinder
//   rf_range/rf_debug_error                RangeFinder result, combinational in finish cycle
//   res_valid/res_ready/res_id/res_range/res_error  result handshake to the winner
module range_sequencer
  import range_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      rf_data_in,
  output logic                  rf_go,
  output logic                  rf_finish,
  input  logic [WIDTH-1:0]      rf_range,
  input  logic                  rf_debug_error,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [IDW-1:0]        res_id,
  output logic [WIDTH-1:0]      res_range,
  output logic                  res_error
);

  seq_state_t       state, state_nxt;
  logic [IDW-1:0]   owner;
  logic [IDW-1:0]   last_grant;
  logic             first;
  logic [WIDTH-1:0] hold_data;

  logic [NREQ-1:0]  arb_grant;
  logic [IDW-1:0]   arb_id;
  logic             arb_any;

  logic [WIDTH-1:0] req_words [NREQ];
  logic             own_vld;
  logic             own_last;
  logic [WIDTH-1:0] own_dat;
  logic             beat;

  for (genvar i = 0; i < NREQ; i++) begin : g_words
    assign req_words[i] = req_data[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_id   (arb_id),
    .any        (arb_any)
  );

  assign own_vld   = req_valid[owner];
  assign own_last  = req_last[owner];
  assign own_dat   = req_words[owner];
  assign beat      = (state == STREAM) && own_vld;
  assign res_valid = (state == RESULT);

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    rf_go      = 1'b0;
    rf_finish  = 1'b0;
    rf_data_in = '0;
    case (state)
      IDLE: begin
        if (arb_any) state_nxt = STREAM;
      end
      STREAM: begin
        req_ready[owner] = own_vld;
        // The RangeFinder samples every cycle: on a bubble, replaying the
        // last accepted sample leaves its min/max untouched.
        rf_data_in = hold_data;
        if (beat) begin
          rf_data_in = own_dat;
          // A single-sample burst raises neither strobe: go and finish
          // together is an error condition inside the RangeFinder.
          rf_go      = first && !own_last;
          rf_finish  = !first && own_last;
          if (own_last) state_nxt = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IDW'(NREQ - 1);
      first      <= 1'b1;
      hold_data  <= '0;
      res_id     <= '0;
      res_range  <= '0;
      res_error  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && arb_any) begin
        owner      <= arb_id;
        last_grant <= arb_id;
        first      <= 1'b1;
      end
      if (beat) begin
        hold_data <= own_dat;
        first     <= 1'b0;
        if (own_last) begin
          res_id    <= owner;
          res_range <= first ? '0 : rf_range;
          res_error <= first ? 1'b0 : rf_debug_error;
        end
      end
    end
  end

  a_go_finish_excl : assert property (@(posedge clock) disable iff (!reset)
    !(rf_go && rf_finish));
  a_ready_onehot0 : assert property (@(posedge clock) disable iff (!reset)
    $onehot0(req_ready));
  a_arb_onehot : assert property (@(posedge clock) disable iff (!reset)
    arb_any |-> (arb_grant == (NREQ'(1) << arb_id)));

endmodule
